rc_bist: RTL and testbench
==========================

# rc_bist

Synthesizable self-test engine for the `rc` block (z = x OR y, w = x AND y). On a start pulse it drives `rc` inputs through the four input patterns, waits a settle time per pattern, samples `z`/`w`, compares them with the expected values, and reports pass/fail with per-pattern failure flags. It sits on the driving end of the `rc` interface: its `x`/`y` outputs go to `rc`, and `rc`'s `z`/`w` come back to it.

## Interface
- `SETTLE`, default 2: cycles each pattern is held before sampling; legal range 1..15.
- `clock`  in  1  rising-edge clock.
- `reset_`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE and DONE.
- `z`  in  1  `rc` output z (expected x|y).
- `w`  in  1  `rc` output w (expected x&y).
- `x`  out  1  registered drive to `rc` input x.
- `y`  out  1  registered drive to `rc` input y.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next accepted start.
- `pass`  out  1  high with `done` when no pattern failed.
- `err_count`  out  3  number of failed patterns, 0..4.
- `fail_vec`  out  4  bit i set when pattern i failed.

## Operation
- Pattern order, as {x,y}: idx0 = 00, idx1 = 10, idx2 = 01, idx3 = 11.
- Expected {z,w} per pattern: 00, 10, 10, 11.
- A pattern fails when either `z` or `w` mismatches. Comparison uses `==`.
- State machine:
  - IDLE: `x`=`y`=0, `busy`=0. When `start`=1, the run is accepted: go to RUN with idx=0, cnt=SETTLE-1, `fail_vec`=0, `err_count`=0, `done`=0, `pass`=0.
  - RUN: `busy`=1, `x`/`y` = pattern[idx].
    - If cnt≠0: decrement cnt.
    - If cnt=0: sample `z`/`w` at this edge. On mismatch, set `fail_vec[idx]` and increment `err_count`.
    - Then, if idx<3: idx++, cnt=SETTLE-1. If idx=3: go to DONE.
  - DONE: `x`=`y`=0, `busy`=0, `done`=1, `pass`=(err_count==0 including the final sample). Results hold indefinitely. `start`=1 restarts the run exactly as from IDLE.
- `start` is ignored while `busy`=1.
- `err_count` always equals popcount(`fail_vec`). It never wraps, since the maximum is 4.

## Timing
- Reset (asynchronous, `reset_`=0):
  - state=IDLE.
  - `x`=`y`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0.
- Reset asserted mid-run aborts immediately to these values. After release, no run starts until a new `start`.
- Start acceptance, with edge E0 sampling `start`=1:
  - After E0: `busy`=1 and {x,y}=00.
  - Each pattern is driven for exactly SETTLE cycles.
  - Pattern k is sampled at edge E0+(k+1)·SETTLE.
- At edge E0+4·SETTLE the final sample is taken. In the same cycle `busy` falls and `done`/`pass`/`fail_vec`/`err_count` show final values.
- Total latency from start edge to `done`: 4·SETTLE cycles. With SETTLE=2, that is 8.
- All outputs are registered. There is no combinational path from `z`/`w`/`start` to any output.
- `start` held high continuously: a new run begins on the edge after `done` rises. `done` is then high for exactly one cycle.
- SETTLE=1: the pattern changes every cycle and sampling happens on every RUN edge.

## Test plan
- Correct `rc` model, SETTLE=2, start pulse at edge E0:
  - {x,y} reads 00,00,10,10,01,01,11,11 over the next 8 cycles.
  - At E0+8: `done`=1, `pass`=1, `err_count`=0, `fail_vec`=0000, `busy`=0, {x,y}=00.
- `rc` with z stuck at 0:
  - Final `fail_vec`=1110, `err_count`=3, `pass`=0, `done`=1.
- `rc` with w = x XOR y:
  - Patterns 1, 2 and 3 fail: `fail_vec`=1110, `err_count`=3.
- `rc` with z = x XOR y:
  - Only pattern 3 fails: `fail_vec`=1000, `err_count`=1, `pass`=0.
- Start handling, correct model:
  - Pulse `start` again 3 cycles into a run: it is ignored, and `done` still rises at E0+8.
  - After `done`, a new `start` clears `done`/`fail_vec` on the next edge and repeats the sequence.
- Reset during run:
  - Drive `reset_`=0 at cycle 5 of a run. Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, `busy` stays 0 until `start`.

Source files
------------

// File: rtl/rc_bist.sv
// Self-test engine for the rc block (z = x | y, w = x & y): walks the four
// input patterns, samples z/w after a settle time and reports pass/fail.
module rc_bist #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       start,
  input  logic       z,
  input  logic       w,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;

  logic       exp_z, exp_w, miss;
  logic [1:0] idx_next;
  logic [3:0] fail_vec_next;
  logic [2:0] err_count_next;

  // Pattern order {x,y}: 00, 10, 01, 11; x/y are registered so they already
  // hold pattern[idx] whenever z/w are sampled.
  always_comb begin
    exp_z          = x | y;
    exp_w          = x & y;
    miss           = !((z == exp_z) && (w == exp_w));
    idx_next       = idx + 2'd1;
    fail_vec_next  = fail_vec | (4'(miss) << idx);
    err_count_next = err_count + {2'b00, miss};
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            idx       <= '0;
            cnt       <= CNT_INIT;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            fail_vec  <= fail_vec_next;
            err_count <= err_count_next;
            if (idx != 2'd3) begin
              idx <= idx_next;
              cnt <= CNT_INIT;
              x   <= idx_next[0];
              y   <= idx_next[1];
            end else begin
              state <= DONE;
              x     <= 1'b0;
              y     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count_next == 3'd0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_bist.sv
// Bench for rc_bist: a switchable rc model (good and faulty variants) in front
// of the engine, expected results queued at start and checked on done.
module tb_rc_bist;

  localparam int unsigned SETTLE = 2;

  logic       clock = 1'b0;
  logic       reset_ = 1'b0;
  logic       start = 1'b0;
  logic       z, w, x, y, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  int         mode = 0;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       ps;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  rc_bist #(.SETTLE(SETTLE)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .start     (start),
    .z         (z),
    .w         (w),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  // rc model: 0 good, 1 z stuck at 0, 2 w = x^y, 3 z = x^y
  always_comb begin
    z = x | y;
    w = x & y;
    case (mode)
      1: z = 1'b0;
      2: w = x ^ y;
      3: z = x ^ y;
      default: ;
    endcase
  end

  task automatic chk(input string name, input int act, input int req);
    assertions++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: per-cycle drive sequence while busy, result check on done rise.
  logic [1:0] exp_xy [4];
  logic       busy_prev = 1'b0;
  logic       done_prev = 1'b0;
  int         run_cyc = 0;

  initial begin
    exp_xy[0] = 2'b00;
    exp_xy[1] = 2'b10;
    exp_xy[2] = 2'b01;
    exp_xy[3] = 2'b11;
  end

  always @(negedge clock) begin
    exp_t e;
    if (busy) begin
      if (!busy_prev) run_cyc = 0;
      else run_cyc++;
      if (run_cyc < 4 * SETTLE)
        chk("xy_seq", {x, y}, exp_xy[run_cyc / SETTLE]);
      else
        chk("run_too_long", run_cyc, 4 * SETTLE - 1);
    end
    if (done && !done_prev) begin
      chk("latency", run_cyc, 4 * SETTLE - 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("fail_vec", fail_vec, e.fv);
        chk("err_count", err_count, e.ec);
        chk("pass", pass, e.ps);
        chk("busy_at_done", busy, 0);
        chk("xy_at_done", {x, y}, 0);
      end
    end
    busy_prev = busy;
    done_prev = done;
  end

  task automatic push(input logic [3:0] fv, input logic [2:0] ec, input logic ps);
    exp_t e;
    e.fv = fv; e.ec = ec; e.ps = ps;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_done_timeout"}, int'(done), 1);
  endtask

  task automatic run(input int m, input logic [3:0] fv, input logic [2:0] ec,
                     input logic ps, input string name);
    mode = m;
    push(fv, ec, ps);
    pulse_start();
    wait_done(name);
    @(negedge clock);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ec", err_count, 0);
    chk("rst_fv", fail_vec, 0);
    chk("rst_xy", {x, y}, 0);
    @(negedge clock); reset_ = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_busy", busy, 0);

    run(0, 4'b0000, 3'd0, 1'b1, "good");
    chk("done_holds", done, 1);
    run(1, 4'b1110, 3'd3, 1'b0, "z_stuck0");
    run(2, 4'b1110, 3'd3, 1'b0, "w_xor");
    run(3, 4'b1000, 3'd1, 1'b0, "z_xor");

    // restart from DONE clears results on the next edge
    mode = 0;
    push(4'b0000, 3'd0, 1'b1);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("restart_done_clr", done, 0);
    chk("restart_fv_clr", fail_vec, 0);
    chk("restart_busy", busy, 1);
    // start during a run is ignored
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done("ignored_start");
    @(negedge clock);

    // start held high: back-to-back runs, done high one cycle
    push(4'b0000, 3'd0, 1'b1);
    push(4'b0000, 3'd0, 1'b1);
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    wait_done("held_1");
    @(negedge clock);
    chk("held_done_1cyc", done, 0);
    chk("held_rerun_busy", busy, 1);
    start = 1'b0;
    wait_done("held_2");
    @(negedge clock);

    // asynchronous reset mid-run
    push(4'b0000, 3'd0, 1'b1);
    pulse_start();
    repeat (4) @(negedge clock);
    #2 reset_ = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ec", err_count, 0);
    chk("arst_fv", fail_vec, 0);
    chk("arst_xy", {x, y}, 0);
    void'(exp_q.pop_back());
    @(negedge clock); reset_ = 1'b1;
    repeat (4) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
